weight_fetch_sequencer: RTL

Sequences burst reads from the weight memory (7-bit row address, 32 x 32-bit weights per row, registered read) for the convolution/FC datapath. On a start command it issues a contiguous run of row addresses and captures each returned row into a 4-entry buffer. It presents the rows to the consuming MAC array over a valid/ready stream, with a last flag and a done pulse. It is the only master of the weight memory address port.

---
 rtl/weight_fetch_sequencer_if.sv | 28 ++
 rtl/weight_fetch_sequencer.sv | 89 ++++++++
 2 files changed

// File: rtl/weight_fetch_sequencer_if.sv
// weight_fetch_sequencer_if: command, weight-memory and row-stream signals of the weight fetch sequencer
interface weight_fetch_sequencer_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int ROW_WIDTH  = 1024,
  parameter int CNT_WIDTH  = 8
);
  logic                  start;
  logic                  abort;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [CNT_WIDTH-1:0]  row_count;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [ROW_WIDTH-1:0]  weights_in;
  logic [ROW_WIDTH-1:0]  w_data;
  logic                  w_valid;
  logic                  w_ready;
  logic [ADDR_WIDTH-1:0] w_index;
  logic                  w_last;
  logic                  busy;
  logic                  done;
  modport master (
    input  start, abort, base_addr, row_count, weights_in, w_ready,
    output mem_address, w_data, w_valid, w_index, w_last, busy, done
  );
  modport slave (
    output start, abort, base_addr, row_count, weights_in, w_ready,
    input  mem_address, w_data, w_valid, w_index, w_last, busy, done
  );
endinterface

// File: rtl/weight_fetch_sequencer.sv
// weight_fetch_sequencer: burst-reads weight rows into a 4-entry buffer and streams them to the MAC array
module weight_fetch_sequencer #(
  parameter int ADDR_WIDTH  = 7,
  parameter int ROW_WIDTH   = 1024,
  parameter int CNT_WIDTH   = 8,
  parameter int MEM_LATENCY = 1
) (
  input logic clk,
  input logic reset_n,
  weight_fetch_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} state_t;
  localparam logic [CNT_WIDTH-1:0] MAX_ROWS = CNT_WIDTH'(1 << ADDR_WIDTH);
  state_t state, state_n;
  logic [CNT_WIDTH-1:0] req, cnt, issued;
  logic [MEM_LATENCY:0] tags;
  logic [ROW_WIDTH-1:0] rows [4];
  logic [1:0] rp, wp;
  logic [2:0] occ, occ_n;
  logic [3:0] load;
  logic launch, issue, push, pop, aborting;
  assign req = bus.row_count > MAX_ROWS ? MAX_ROWS : bus.row_count;
  assign launch = state == IDLE && bus.start;
  // buffered rows plus rows still travelling through the memory pipeline
  assign load = 4'(occ) + 4'($countones(tags));
  assign issue = (launch && req != '0) || (state == FETCH && !bus.abort && issued < cnt && load < 4'd4);
  assign push = tags[MEM_LATENCY] && !aborting && !bus.abort;
  assign pop = bus.w_valid && bus.w_ready;
  assign occ_n = occ + 3'(push) - 3'(pop);
  assign bus.w_valid = occ != '0;
  assign bus.w_data = bus.w_valid ? rows[rp] : '0;
  assign bus.w_last = bus.w_valid && CNT_WIDTH'(bus.w_index) == cnt - CNT_WIDTH'(1);
  assign bus.busy = state != IDLE;
  assign bus.done = state == FINISH;
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  // next-state: finish only once nothing is buffered or still returning from memory
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start) state_n = req == '0 ? FINISH : FETCH;
      FETCH:   if (bus.abort || issued + CNT_WIDTH'(issue) == cnt) state_n = DRAIN;
      DRAIN:   if (tags[MEM_LATENCY-1:0] == '0 && (bus.abort || occ_n == '0)) state_n = FINISH;
      default: state_n = IDLE;
    endcase
  end
  // address issue, in-flight tags, buffer pointers and beat index
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bus.mem_address <= '0;
      bus.w_index <= '0;
      cnt <= '0;
      issued <= '0;
      tags <= '0;
      rp <= '0;
      wp <= '0;
      occ <= '0;
      aborting <= 1'b0;
    end else begin
      tags <= {tags[MEM_LATENCY-1:0], issue};
      if (issue) begin
        bus.mem_address <= launch ? bus.base_addr : bus.mem_address + ADDR_WIDTH'(1);
        issued <= launch ? CNT_WIDTH'(1) : issued + CNT_WIDTH'(1);
      end
      if (launch) begin
        cnt <= req;
        aborting <= 1'b0;
        bus.w_index <= '0;
      end
      if (bus.abort && state != IDLE) begin
        aborting <= 1'b1;
        rp <= '0;
        wp <= '0;
        occ <= '0;
      end else begin
        if (push) wp <= wp + 2'd1;
        if (pop) begin
          rp <= rp + 2'd1;
          bus.w_index <= bus.w_index + ADDR_WIDTH'(1);
        end
        occ <= occ_n;
      end
    end
  // row storage; contents are only visible while counted as occupied
  always_ff @(posedge clk)
    if (push) rows[wp] <= bus.weights_in;
endmodule
